// File: rtl/fault_injector.sv
// Serial-loaded fault injector.
// A controller shifts frames in over i_SERIAL_IN while i_EN_SR is high: two ctrl bits
// (MSB first) select the fault type, and the remaining bits shift into the fault mask.
// Once a frame has delivered at least one mask bit the block is armed. i_TFEn then
// starts injection, which corrupts the registered data path until a soft clear
// (i_RST) or a system reset (i_RST_SYS).
//
// Ports:
//   i_CLK_SYS     system clock, rising edge
//   i_RST_SYS     asynchronous active-low reset
//   i_SERIAL_IN   serial frame bit
//   i_EN_SR       shift enable; one high run equals one frame
//   i_TFEn        trigger pulse, honoured only in ARMED with i_EN_SR low
//   i_RST         synchronous soft clear, active-high, highest priority
//   i_FUNC_DATA   functional data
//   o_FAULT_DATA  registered, possibly faulted copy of i_FUNC_DATA
//   o_ACTIVE      high in INJECT
//   o_ARMED       high in ARMED
//   o_ERR         sticky protocol-error flag
//   o_OVF         sticky flag: more than N mask bits since the last clear
module fault_injector #(
   parameter int unsigned N = 64
) (
   input  logic         i_CLK_SYS,
   input  logic         i_RST_SYS,
   input  logic         i_SERIAL_IN,
   input  logic         i_EN_SR,
   input  logic         i_TFEn,
   input  logic         i_RST,
   input  logic [N-1:0] i_FUNC_DATA,
   output logic [N-1:0] o_FAULT_DATA,
   output logic         o_ACTIVE,
   output logic         o_ARMED,
   output logic         o_ERR,
   output logic         o_OVF
);

   // The counter is at least 7 bits wide and is always wide enough to hold N+1.
   localparam int unsigned CntWRaw = $clog2(N + 2);
   localparam int unsigned CntW    = (CntWRaw > 7) ? CntWRaw : 7;
   localparam logic [CntW-1:0] NCnt = CntW'(N);

   typedef enum logic [2:0] {StIdle, StCtrl, StLoad, StArmed, StInject} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    mask_q, mask_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic [N-1:0]    fault_q, fault_d;

   // Next-state logic for the frame receiver and injection control.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      if (i_RST) begin
         state_d = StIdle;
         mask_d  = '0;
         ctrl_d  = 2'b00;
         cnt_d   = '0;
         err_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         // A trigger is legal only in ARMED with no frame in progress.
         if (i_TFEn && ((state_q != StArmed) || i_EN_SR)) begin
            err_d = 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (i_EN_SR) begin
                  ctrl_d[1] = i_SERIAL_IN;
                  state_d   = StCtrl;
               end
            end
            StCtrl: begin
               if (i_EN_SR) begin
                  ctrl_d[0] = i_SERIAL_IN;
                  state_d   = StLoad;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
            StLoad: begin
               if (i_EN_SR) begin
                  mask_d = {mask_q[N-2:0], i_SERIAL_IN};
                  // N bits are already held, so this bit pushes one out of the mask.
                  if (cnt_q >= NCnt) begin
                     ovf_d = 1'b1;
                  end
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end else if (cnt_q != '0) begin
                  state_d = StArmed;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
            StArmed: begin
               // A new frame overwrites ctrl but keeps accumulating into the mask.
               if (i_EN_SR) begin
                  ctrl_d[1] = i_SERIAL_IN;
                  state_d   = StCtrl;
               end else if (i_TFEn) begin
                  state_d = StInject;
               end
            end
            StInject: begin
               if (i_EN_SR) begin
                  err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // The data path keeps passing data through on the soft-clear edge itself.
   always_comb begin
      fault_d = i_FUNC_DATA;
      if ((state_q == StInject) && !i_RST) begin
         unique case (ctrl_q)
            2'b00:   fault_d = i_FUNC_DATA & ~mask_q;
            2'b01:   fault_d = i_FUNC_DATA | mask_q;
            2'b10:   fault_d = i_FUNC_DATA ^ mask_q;
            default: fault_d = i_FUNC_DATA;
         endcase
      end
   end

   always_ff @(posedge i_CLK_SYS or negedge i_RST_SYS) begin
      if (!i_RST_SYS) begin
         state_q <= StIdle;
         mask_q  <= '0;
         ctrl_q  <= 2'b00;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         fault_q <= fault_d;
      end
   end

   assign o_FAULT_DATA = fault_q;
   assign o_ACTIVE     = (state_q == StInject);
   assign o_ARMED      = (state_q == StArmed);
   assign o_ERR        = err_q;
   assign o_OVF        = ovf_q;

endmodule

// File: tb/tb_fault_injector.sv
// Directed bench for fault_injector (N = 64): a vector table of single-frame
// injections plus hand-written sequences for multi-frame masks, protocol errors,
// mask overflow, soft clear and asynchronous reset during injection.
module tb_fault_injector;

   localparam int unsigned N = 64;

   logic         clk;
   logic         rst_n;
   logic         ser;
   logic         en;
   logic         tfen;
   logic         srst;
   logic [N-1:0] data;
   logic [N-1:0] fault_data;
   logic         active;
   logic         armed;
   logic         err;
   logic         ovf;

   int n_tests = 0;
   int n_fail  = 0;

   fault_injector #(.N(N)) dut (
      .i_CLK_SYS    (clk),
      .i_RST_SYS    (rst_n),
      .i_SERIAL_IN  (ser),
      .i_EN_SR      (en),
      .i_TFEn       (tfen),
      .i_RST        (srst),
      .i_FUNC_DATA  (data),
      .o_FAULT_DATA (fault_data),
      .o_ACTIVE     (active),
      .o_ARMED      (armed),
      .o_ERR        (err),
      .o_OVF        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [1:0]   ctrl;
      logic [64:0]  bits;
      int           nbits;
      logic [N-1:0] din;
      logic [N-1:0] exp_fault;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic soft_clear();
      srst = 1'b1;
      step();
      srst = 1'b0;
   endtask

   // Sends ctrl (MSB first) then nb mask bits, MSB of the nb-bit field first,
   // then drops i_EN_SR for one cycle.
   task automatic send_frame(input logic [1:0] c, input logic [64:0] bits, input int nb);
      en  = 1'b1;
      ser = c[1];
      step();
      ser = c[0];
      step();
      for (int i = 0; i < nb; i++) begin
         ser = bits[nb-1-i];
         step();
      end
      en  = 1'b0;
      ser = 1'b0;
      step();
   endtask

   // Trigger pulse, then one more edge so the faulted word is registered.
   task automatic fire();
      tfen = 1'b1;
      step();
      tfen = 1'b0;
      step();
   endtask

   initial begin
      logic [N-1:0] exp_mask;

      vecs[0] = '{"sa1_16b", 2'b01, 65'h000B, 16, 64'h0,
                  64'h0000_0000_0000_000B, 1'b0};
      vecs[1] = '{"sa0_32b", 2'b00, 65'h0002_96FB, 32, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFD_6904, 1'b0};
      vecs[2] = '{"flip_16b", 2'b10, 65'hF0F0, 16, 64'h0000_0000_0000_00FF,
                  64'h0000_0000_0000_F00F, 1'b0};
      vecs[3] = '{"pass_16b", 2'b11, 65'hFFFF, 16, 64'h0000_0000_0000_1234,
                  64'h0000_0000_0000_1234, 1'b0};
      vecs[4] = '{"sa1_64b", 2'b01, 65'h0_8000_0000_0000_0001, 64, 64'h0,
                  64'h8000_0000_0000_0001, 1'b0};

      rst_n = 1'b0;
      ser   = 1'b0;
      en    = 1'b0;
      tfen  = 1'b0;
      srst  = 1'b0;
      data  = 64'hA5A5_A5A5_A5A5_A5A5;
      #3;
      check("rst_fault", fault_data, 64'h0);
      check("rst_active", {63'h0, active}, 64'h0);
      check("rst_armed", {63'h0, armed}, 64'h0);
      check("rst_err", {63'h0, err}, 64'h0);
      check("rst_ovf", {63'h0, ovf}, 64'h0);
      #4;
      rst_n = 1'b1;
      step();
      check("pass_idle", fault_data, 64'hA5A5_A5A5_A5A5_A5A5);

      // Table of single-frame injections.
      for (int v = 0; v < 5; v++) begin
         soft_clear();
         data = vecs[v].din;
         send_frame(vecs[v].ctrl, vecs[v].bits, vecs[v].nbits);
         check({vecs[v].name, "_armed"}, {63'h0, armed}, 64'h1);
         fire();
         check({vecs[v].name, "_active"}, {63'h0, active}, 64'h1);
         check({vecs[v].name, "_fault"}, fault_data, vecs[v].exp_fault);
         check({vecs[v].name, "_ovf"}, {63'h0, ovf}, {63'h0, vecs[v].exp_ovf});
         check({vecs[v].name, "_err"}, {63'h0, err}, 64'h0);
      end

      // Two frames build a 54-bit mask, first word in the upper bits.
      soft_clear();
      data = 64'hFFFF_FFFF_FFFF_FFFF;
      send_frame(2'b00, 65'hDEAD_BEEF, 32);
      send_frame(2'b00, 65'h2A_BCDE, 22);
      fire();
      exp_mask = (64'hDEAD_BEEF << 22) | 64'h2A_BCDE;
      check("multi_fault", fault_data, ~exp_mask);
      check("multi_ovf", {63'h0, ovf}, 64'h0);
      check("multi_active", {63'h0, active}, 64'h1);

      // Shift enable during injection is ignored but flagged.
      en = 1'b1;
      step();
      en = 1'b0;
      step();
      check("inj_en_err", {63'h0, err}, 64'h1);
      check("inj_en_active", {63'h0, active}, 64'h1);

      // Asynchronous reset mid-cycle clears outputs without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_active", {63'h0, active}, 64'h0);
      check("async_fault", fault_data, 64'h0);
      check("async_err", {63'h0, err}, 64'h0);
      #1;
      rst_n = 1'b1;
      step();

      // One-cycle frame: aborted in CTRL.
      en  = 1'b1;
      ser = 1'b1;
      step();
      en  = 1'b0;
      ser = 1'b0;
      step();
      check("short_err", {63'h0, err}, 64'h1);
      check("short_armed", {63'h0, armed}, 64'h0);
      check("short_active", {63'h0, active}, 64'h0);

      // Trigger in IDLE.
      soft_clear();
      check("clr_err", {63'h0, err}, 64'h0);
      tfen = 1'b1;
      step();
      tfen = 1'b0;
      step();
      check("idle_tf_err", {63'h0, err}, 64'h1);
      check("idle_tf_active", {63'h0, active}, 64'h0);

      // Frame with no mask bits: ctrl only, then EN_SR drops in LOAD.
      soft_clear();
      send_frame(2'b01, 65'h0, 0);
      check("empty_err", {63'h0, err}, 64'h1);
      check("empty_armed", {63'h0, armed}, 64'h0);

      // N+1 mask bits: overflow, mask keeps the last N.
      soft_clear();
      data = 64'h0;
      send_frame(2'b10, {1'b1, 64'h0123_4567_89AB_CDEF}, 65);
      check("ovf_flag", {63'h0, ovf}, 64'h1);
      fire();
      check("ovf_fault", fault_data, 64'h0123_4567_89AB_CDEF);

      // Soft clear drops all flags and returns to pass-through.
      data = 64'h0000_0000_0000_0055;
      srst = 1'b1;
      step();
      srst = 1'b0;
      check("sclr_ovf", {63'h0, ovf}, 64'h0);
      check("sclr_err", {63'h0, err}, 64'h0);
      check("sclr_active", {63'h0, active}, 64'h0);
      check("sclr_fault", fault_data, 64'h0000_0000_0000_0055);
      data = 64'h0000_0000_0000_00AA;
      step();
      check("sclr_pass", fault_data, 64'h0000_0000_0000_00AA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fault_injector.md
FAULT_INJECTOR -- requirements
Module: fault_injector

Interface
REQ-001 Parameter: N, default 64, meaning width of the fault mask register and of the protected data path.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 i_CLK_SYS  input  1  system clock; all state on rising edge.
REQ-004 i_RST_SYS  input  1  asynchronous active-low reset.
REQ-005 i_SERIAL_IN  input  1  serial frame bit from the upstream controller's serial output.
REQ-006 i_EN_SR  input  1  shift enable; one contiguous high run equals one frame, one bit per cycle.
REQ-007 i_TFEn  input  1  trigger-fault pulse; arms injection.
REQ-008 i_RST  input  1  synchronous soft clear from the controller, active-high.
REQ-009 i_FUNC_DATA  input  N  functional data to be faulted.
REQ-010 o_FAULT_DATA  output  N  registered, possibly faulted copy of i_FUNC_DATA.
REQ-011 o_ACTIVE  output  1  high while injection is applied.
REQ-012 o_ARMED  output  1  high when a valid mask is loaded and awaits i_TFEn.
REQ-013 o_ERR  output  1  sticky protocol-error flag.
REQ-014 o_OVF  output  1  sticky flag: more than N mask bits received since last clear.

Function
REQ-015 Frame format SHALL be: first 2 bits = ctrl[1:0], MSB first; remaining bits = mask bits.
REQ-016 Each mask bit SHALL shift into mask[0] with mask shifted left by one; bits leaving mask[N-1] are discarded.
REQ-017 ctrl encoding SHALL be: 00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 no fault (pass-through).
REQ-018 States SHALL be IDLE, CTRL, LOAD, ARMED, INJECT.
REQ-019 IDLE -> CTRL on i_EN_SR high; that cycle's bit SHALL be captured as ctrl[1].
REQ-020 CTRL -> LOAD after the second ctrl bit; i_EN_SR falling in CTRL SHALL set o_ERR and return to IDLE, mask unchanged.
REQ-021 LOAD -> ARMED when i_EN_SR falls and at least one mask bit has been received since the last clear; otherwise -> IDLE with o_ERR set.
REQ-022 A new frame starting in ARMED SHALL re-enter CTRL, overwrite ctrl, and keep accumulating into the existing mask (multi-frame masks).
REQ-023 A 7-bit-min saturating bit counter SHALL count mask bits; when it exceeds N, o_OVF SHALL be set.
REQ-024 i_TFEn in ARMED with i_EN_SR low SHALL move to INJECT on the next edge.
REQ-025 i_TFEn in any other state, or concurrent with i_EN_SR high, SHALL be ignored and set o_ERR.
REQ-026 INJECT SHALL persist until i_RST or i_RST_SYS; i_EN_SR in INJECT SHALL be ignored and set o_ERR.
REQ-027 o_FAULT_DATA SHALL equal i_FUNC_DATA delayed one cycle outside INJECT.
REQ-028 In INJECT, o_FAULT_DATA SHALL be (D & ~mask) for 00, (D | mask) for 01, (D ^ mask) for 10, and D for 11, with one-cycle latency.
REQ-029 o_ACTIVE SHALL be high exactly in INJECT; o_ARMED SHALL be high exactly in ARMED.
REQ-030 i_RST SHALL have priority over all other inputs: state IDLE, mask, ctrl, counter, o_ERR and o_OVF cleared next edge; o_FAULT_DATA keeps pass-through.

Reset
REQ-031 While i_RST_SYS is low: state IDLE, mask 0, ctrl 00, counter 0, o_FAULT_DATA 0, o_ACTIVE 0, o_ARMED 0, o_ERR 0, o_OVF 0.
REQ-032 Reset asserted mid-frame or mid-injection SHALL abort immediately with no partial mask retained.

Verification
REQ-033 Frame ctrl=01 plus 16 mask bits 0x000B, then i_TFEn, i_FUNC_DATA=0 -> o_FAULT_DATA=0x000B one cycle after INJECT entry, o_ACTIVE=1.
REQ-034 Frame ctrl=00 plus 32 mask bits 0x0002_96FB, i_FUNC_DATA all ones, i_TFEn -> o_FAULT_DATA = ~0x0002_96FB in the low 32 bits, upper bits 1.
REQ-035 Two frames (ctrl=00 + 32 bits, then ctrl=00 + 22 bits), i_TFEn -> mask equals the 54-bit concatenation, first word in the upper bits; o_OVF=0.
REQ-036 i_EN_SR high for 1 cycle only -> o_ERR=1, state IDLE; i_TFEn in IDLE -> o_ERR=1, o_ACTIVE stays 0.
REQ-037 N+1 mask bits -> o_OVF=1, mask holds the last N bits; i_RST -> all flags 0, o_FAULT_DATA returns to pass-through.
REQ-038 i_RST_SYS low during INJECT -> o_ACTIVE and o_FAULT_DATA 0 immediately, without waiting for a clock edge.
